// File: rtl/brightness_pkg.sv
// Shared definitions for the brightness PWM path (generator and capture).
// Holds the channel count, duty width, FSM state encoding and the mapping
// from a channel index to its byte position in the 48-bit brightness word.
package brightness_pkg;

    localparam int NUM_CH = 6;
    localparam int DUTY_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARM     = 2'b01,
        MEASURE = 2'b10
    } state_t;

    // Channel n occupies word[8n+7:8n]; returns the LSB index of that slice.
    function automatic int unsigned ch_lsb(input int unsigned ch);
        return ch * DUTY_W;
    endfunction

endpackage

// File: rtl/brightness_pwm_capture_pwm_duty_counter.sv
// One capture channel: input synchronizer, high-sample accumulator and the
// scaler that turns a window total into an 8-bit duty value.
// Ports:
//   sys_clk, sys_resetb : clock, asynchronous active-low reset
//   pwm_async           : raw PWM input, asynchronous to sys_clk
//   run                 : accumulate this cycle (MEASURE with enable high)
//   win_end             : last cycle of the window; accumulator reloads
//   duty                : scaled, saturated duty for the window ending now
//   all_high, all_low   : window total is full-scale / zero
// duty and the flags are combinational and only meaningful while win_end
// is high; the parent registers them.
module pwm_duty_counter
    import brightness_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              sys_resetb,
    input  logic              pwm_async,
    input  logic              run,
    input  logic              win_end,
    output logic [DUTY_W-1:0] duty,
    output logic              all_high,
    output logic              all_low
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   bit_s;
    logic [WINDOW_LOG2:0]   acc_r;
    logic [WINDOW_LOG2:0]   total_s;
    logic [WINDOW_LOG2:0]   scaled_s;

    // Synchronizer chain; runs in every state, cleared only by reset.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_async};
        end
    end

    assign bit_s   = sync_r[SYNC_STAGES-1];
    // The current sample is added here so the window-end cycle counts too.
    assign total_s = acc_r + {{WINDOW_LOG2{1'b0}}, bit_s};

    // Accumulator: reloads with 0 at window end so windows abut with no gap,
    // and is discarded whenever measurement is not running.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            acc_r <= '0;
        end else if (run && !win_end) begin
            acc_r <= total_s;
        end else begin
            acc_r <= '0;
        end
    end

    assign scaled_s = total_s >> (WINDOW_LOG2 - DUTY_W);

    // Saturating scaler: a full-scale window (2^WINDOW_LOG2) would be 256.
    always_comb begin
        duty = scaled_s[DUTY_W-1:0];
        if (|scaled_s[WINDOW_LOG2:DUTY_W]) begin
            duty = 8'hFF;
        end else begin
            duty = scaled_s[DUTY_W-1:0];
        end
    end

    assign all_high = (total_s == {1'b1, {WINDOW_LOG2{1'b0}}});
    assign all_low  = (total_s == '0);

endmodule

// File: rtl/brightness_pwm_capture.sv
// Decodes six PWM brightness channels back into a 48-bit brightness word.
// Each channel's high time is measured over back-to-back windows of
// 2^WINDOW_LOG2 cycles and reported as an 8-bit duty value.
// Ports:
//   sys_clk, sys_resetb : clock, asynchronous active-low reset
//   en_i                : capture enable (level)
//   pwm_i[5:0]          : PWM inputs; bit n maps to data_o[8n+7:8n]
//   data_o              : decoded duty word, registered
//   cts_o               : one-cycle pulse coincident with new data_o
//   stuck_high_o/low_o  : channel constant high/low over the last window
module brightness_pwm_capture
    import brightness_pkg::*;
#(
    parameter int WINDOW_LOG2 = 8,
    parameter int SYNC_STAGES = 2,
    parameter bit CHANGE_ONLY = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_resetb,
    input  logic        en_i,
    input  logic [5:0]  pwm_i,
    output logic [47:0] data_o,
    output logic        cts_o,
    output logic [5:0]  stuck_high_o,
    output logic [5:0]  stuck_low_o
);

    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

    state_t                 state_r;
    state_t                 state_s;
    logic [ARM_W-1:0]       arm_cnt_r;
    logic [WINDOW_LOG2-1:0] win_cnt_r;
    logic                   first_r;
    logic                   run_s;
    logic                   win_end_s;
    logic [47:0]            new_word_s;
    logic [5:0]             all_high_s;
    logic [5:0]             all_low_s;

    // Measurement stops in the very cycle en_i falls, so gate with en_i.
    assign run_s     = (state_r == MEASURE) && en_i;
    assign win_end_s = run_s && (win_cnt_r == '1);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (en_i) begin
                    state_s = ARM;
                end else begin
                    state_s = IDLE;
                end
            end
            ARM: begin
                if (!en_i) begin
                    state_s = IDLE;
                end else if (arm_cnt_r == ARM_LAST) begin
                    state_s = MEASURE;
                end else begin
                    state_s = ARM;
                end
            end
            MEASURE: begin
                if (!en_i) begin
                    state_s = IDLE;
                end else begin
                    state_s = MEASURE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // ARM dwell counter: holds the FSM long enough to flush the synchronizers.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            arm_cnt_r <= '0;
        end else if ((state_r == ARM) && en_i) begin
            arm_cnt_r <= arm_cnt_r + ARM_W'(1);
        end else begin
            arm_cnt_r <= '0;
        end
    end

    // Window counter; wraps naturally at the window end.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            win_cnt_r <= '0;
        end else if (run_s) begin
            win_cnt_r <= win_cnt_r + WINDOW_LOG2'(1);
        end else begin
            win_cnt_r <= '0;
        end
    end

    // Marks the first window after ARM so it always strobes.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            first_r <= 1'b0;
        end else if (state_r == ARM) begin
            first_r <= 1'b1;
        end else if (win_end_s) begin
            first_r <= 1'b0;
        end else begin
            first_r <= first_r;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam int LSB = ch_lsb(g);
        pwm_duty_counter #(
            .WINDOW_LOG2 (WINDOW_LOG2),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_cnt (
            .sys_clk    (sys_clk),
            .sys_resetb (sys_resetb),
            .pwm_async  (pwm_i[g]),
            .run        (run_s),
            .win_end    (win_end_s),
            .duty       (new_word_s[LSB +: DUTY_W]),
            .all_high   (all_high_s[g]),
            .all_low    (all_low_s[g])
        );
    end

    // Output registers: data, flags and the strobe all update on window end.
    always_ff @(posedge sys_clk or negedge sys_resetb) begin
        if (!sys_resetb) begin
            data_o       <= '0;
            cts_o        <= 1'b0;
            stuck_high_o <= '0;
            stuck_low_o  <= '0;
        end else if (win_end_s) begin
            data_o       <= new_word_s;
            stuck_high_o <= all_high_s;
            stuck_low_o  <= all_low_s;
            cts_o        <= !CHANGE_ONLY || first_r || (new_word_s != data_o);
        end else begin
            cts_o        <= 1'b0;
        end
    end

endmodule

// File: tb/tb_brightness_pwm_capture.sv
module tb_brightness_pwm_capture;

    localparam int SYNC = 2;

    typedef struct packed {
        logic [47:0] data;
        logic [5:0]  hi;
        logic [5:0]  lo;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        en_co;
    logic [5:0]  pwm;
    logic [47:0] data;
    logic        cts;
    logic [5:0]  hi;
    logic [5:0]  lo;
    logic [47:0] co_data;
    logic        co_cts;
    logic [5:0]  co_hi;
    logic [5:0]  co_lo;

    int total = 0;
    int bad   = 0;
    exp_t sb_q[$];

    // Generator model state
    logic [7:0]  phase;
    logic [47:0] pending_word;
    logic [47:0] active_word;
    logic [5:0]  force_high;

    brightness_pwm_capture #(.WINDOW_LOG2(8), .SYNC_STAGES(SYNC), .CHANGE_ONLY(1'b0)) dut (
        .sys_clk(clk), .sys_resetb(rst_n), .en_i(en), .pwm_i(pwm),
        .data_o(data), .cts_o(cts), .stuck_high_o(hi), .stuck_low_o(lo));

    brightness_pwm_capture #(.WINDOW_LOG2(8), .SYNC_STAGES(SYNC), .CHANGE_ONLY(1'b1)) dut_co (
        .sys_clk(clk), .sys_resetb(rst_n), .en_i(en_co), .pwm_i(pwm),
        .data_o(co_data), .cts_o(co_cts), .stuck_high_o(co_hi), .stuck_low_o(co_lo));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Free-running 256-cycle PWM generator; new words take effect at phase 0.
    initial begin
        phase        = 8'd0;
        pending_word = 48'h0;
        active_word  = 48'h0;
        force_high   = 6'b0;
        pwm          = 6'b0;
        forever begin
            @(posedge clk);
            #2;
            phase = phase + 8'd1;
            if (phase == 8'd0) active_word = pending_word;
            for (int ch = 0; ch < 6; ch++)
                pwm[ch] = (phase < active_word[ch*8 +: 8]) | force_high[ch];
        end
    end

    task automatic set_word(input logic [47:0] w);
        int n;
        pending_word = w;
        n = 0;
        while (active_word !== w && n < 300) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_cts(input bit which, input int max_cycles, output int cycles, output bit seen);
        cycles = 0;
        seen   = 1'b0;
        while (cycles < max_cycles && !seen) begin
            @(posedge clk);
            #1;
            cycles++;
            if ((which ? co_cts : cts) === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic stop_all();
        @(negedge clk);
        en    = 1'b0;
        en_co = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        en_co = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({data, hi, lo} !== 60'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=0", {data, hi, lo});
        end
        total++;
        if (cts !== 1'b0 || co_cts !== 1'b0) begin
            bad++;
            $display("FAIL reset_cts got=%b%b want=00", cts, co_cts);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_loopback();
        int cyc; bit seen; exp_t e;
        set_word(48'h00_10_40_80_C0_FF);
        sb_q.push_back('{data: 48'h00_10_40_80_C0_FF, hi: 6'b000000, lo: 6'b100000});
        @(negedge clk);
        en = 1'b1;
        wait_cts(1'b0, 600, cyc, seen);
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL loopback_timeout got=no_cts want=cts");
            void'(sb_q.pop_front());
        end else begin
            e = sb_q.pop_front();
            if ({data, hi, lo} !== e) begin
                bad++;
                $display("FAIL loopback_word got=%h/%b/%b want=%h/%b/%b", data, hi, lo, e.data, e.hi, e.lo);
            end
            total++;
            if (cyc < SYNC + 256 || cyc > SYNC + 257) begin
                bad++;
                $display("FAIL loopback_latency got=%0d want=%0d..%0d", cyc, SYNC + 256, SYNC + 257);
            end
            @(posedge clk);
            #1;
            total++;
            if (cts !== 1'b0) begin
                bad++;
                $display("FAIL loopback_pulse_width got=%b want=0", cts);
            end
        end
        stop_all();
    endtask

    task automatic test_stuck();
        int cyc; bit seen; exp_t e;
        set_word(48'h0);
        force_high = 6'b000001;
        repeat (4) @(negedge clk);
        sb_q.push_back('{data: 48'h0000_0000_00FF, hi: 6'b000001, lo: 6'b111110});
        en = 1'b1;
        wait_cts(1'b0, 600, cyc, seen);
        e = sb_q.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL stuck_timeout got=no_cts want=cts");
        end else if ({data, hi, lo} !== e) begin
            bad++;
            $display("FAIL stuck_word got=%h/%b/%b want=%h/%b/%b", data, hi, lo, e.data, e.hi, e.lo);
        end
        stop_all();
        force_high = 6'b0;
    endtask

    task automatic test_phase();
        int cyc; bit seen; exp_t e; int n;
        int offs[3] = '{37, 0, 255};
        set_word({6{8'h5A}});
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (phase != offs[k][7:0] && n < 300) begin
                @(negedge clk);
                n++;
            end
            sb_q.push_back('{data: {6{8'h5A}}, hi: 6'b0, lo: 6'b0});
            en = 1'b1;
            wait_cts(1'b0, 600, cyc, seen);
            e = sb_q.pop_front();
            total++;
            if (!seen) begin
                bad++;
                $display("FAIL phase_timeout off=%0d got=no_cts want=cts", offs[k]);
            end else if ({data, hi, lo} !== e) begin
                bad++;
                $display("FAIL phase_word off=%0d got=%h want=%h", offs[k], data, e.data);
            end
            stop_all();
        end
    endtask

    task automatic test_change_only();
        int cyc; bit seen; exp_t e; int cnt;
        set_word({6{8'h33}});
        sb_q.push_back('{data: {6{8'h33}}, hi: 6'b0, lo: 6'b0});
        @(negedge clk);
        en_co = 1'b1;
        wait_cts(1'b1, 600, cyc, seen);
        e = sb_q.pop_front();
        total++;
        if (!seen || co_data !== e.data) begin
            bad++;
            $display("FAIL co_first_window got=%h seen=%b want=%h", co_data, seen, e.data);
        end
        cnt = 0;
        for (int i = 0; i < 520; i++) begin
            @(posedge clk);
            #1;
            if (co_cts === 1'b1) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL co_unchanged_strobes got=%0d want=0", cnt);
        end
        pending_word = {6{8'h34}};
        sb_q.push_back('{data: {6{8'h34}}, hi: 6'b0, lo: 6'b0});
        wait_cts(1'b1, 800, cyc, seen);
        e = sb_q.pop_front();
        total++;
        if (!seen || co_data !== e.data) begin
            bad++;
            $display("FAIL co_changed_window got=%h seen=%b want=%h", co_data, seen, e.data);
        end
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (co_cts === 1'b1) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL co_after_change_strobes got=%0d want=0", cnt);
        end
        stop_all();
    endtask

    task automatic test_en_drop();
        int cyc; bit seen; exp_t e; int cnt; bit moved;
        set_word({6{8'h20}});
        sb_q.push_back('{data: {6{8'h20}}, hi: 6'b0, lo: 6'b0});
        @(negedge clk);
        en = 1'b1;
        wait_cts(1'b0, 600, cyc, seen);
        e = sb_q.pop_front();
        total++;
        if (!seen || data !== e.data) begin
            bad++;
            $display("FAIL drop_first_window got=%h want=%h", data, e.data);
        end
        // cts is visible during window cycle 0; move on to window cycle 100
        repeat (100) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        set_word({6{8'h77}});
        cnt = 0;
        moved = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (cts === 1'b1) cnt++;
            if (data !== {6{8'h20}}) moved = 1'b1;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL drop_no_cts got=%0d want=0", cnt);
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL drop_data_hold got=%h want=%h", data, {6{8'h20}});
        end
        sb_q.push_back('{data: {6{8'h77}}, hi: 6'b0, lo: 6'b0});
        @(negedge clk);
        en = 1'b1;
        wait_cts(1'b0, 600, cyc, seen);
        e = sb_q.pop_front();
        total++;
        if (!seen || cyc < SYNC + 256 || cyc > SYNC + 257) begin
            bad++;
            $display("FAIL reenable_latency got=%0d want=%0d..%0d", cyc, SYNC + 256, SYNC + 257);
        end
        total++;
        if (data !== e.data) begin
            bad++;
            $display("FAIL reenable_word got=%h want=%h", data, e.data);
        end
    endtask

    task automatic test_reset_mid();
        int cyc; bit seen; exp_t e;
        // dut is still enabled and in its window after the re-enable strobe
        repeat (150) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({data, hi, lo, cts} !== 61'h0) begin
            bad++;
            $display("FAIL midreset_clear got=%h cts=%b want=0", data, cts);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{data: {6{8'h77}}, hi: 6'b0, lo: 6'b0});
        wait_cts(1'b0, 600, cyc, seen);
        e = sb_q.pop_front();
        total++;
        if (!seen || cyc < SYNC + 256 || cyc > SYNC + 257) begin
            bad++;
            $display("FAIL midreset_latency got=%0d want=%0d..%0d", cyc, SYNC + 256, SYNC + 257);
        end
        total++;
        if (data !== e.data) begin
            bad++;
            $display("FAIL midreset_word got=%h want=%h", data, e.data);
        end
        stop_all();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        en_co = 1'b0;
        test_reset();
        test_loopback();
        test_stuck();
        test_phase();
        test_change_only();
        test_en_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
